dcache_port_arbiter: RTL and testbench

Sequences the single data-cache port between the load path (scheduled LSQ loads) and the store-buffer drain (committed stores at the head of the store buffer). Holds one request in flight, replays it after a miss refill, and escalates store priority on store-buffer pressure or load-induced starvation. Sits between the load/store issue logic and the L1 D-cache.

---
 rtl/dcache_port_arbiter_pkg.sv | 30 +++
 rtl/dcache_port_arbiter_if.sv | 56 +++++
 rtl/dcache_port_arbiter_starve_counter.sv | 40 ++++
 rtl/dcache_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and constants for the data-cache port arbiter.
package dcache_port_arbiter_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int MASK_WIDTH       = DATA_WIDTH / 8;
    localparam int TAG_WIDTH        = 5;
    localparam int ST_BUF_N_ENTRIES = 8;
    localparam int ST_CNT_WIDTH     = $clog2(ST_BUF_N_ENTRIES + 1);
    localparam int ST_HI_WATERMARK  = 6;
    localparam int STARVE_LIMIT     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RESP,
        ST_MISS,
        ST_REPLAY
    } dc_arb_state_t;

    // The one request in flight; killed marks a flushed load whose result must be dropped.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  killed;
    } dc_hold_t;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Load path, store-buffer head, cache port and load writeback signals of the arbiter.
// master: the arbiter itself; slave: the surrounding LSU and L1 D-cache.
interface dcache_port_arbiter_if;
    import dcache_port_arbiter_pkg::*;

    logic                    ld_req_valid;
    logic                    ld_req_ready;
    logic [ADDR_WIDTH-1:0]   ld_req_addr;
    logic [TAG_WIDTH-1:0]    ld_req_tag;

    logic                    st_req_valid;
    logic [ADDR_WIDTH-1:0]   st_req_addr;
    logic [DATA_WIDTH-1:0]   st_req_data;
    logic [MASK_WIDTH-1:0]   st_req_wmask;
    logic                    st_req_ready;
    logic [ST_CNT_WIDTH-1:0] st_buf_count;

    logic                    flush;

    logic                    dc_req_valid;
    logic                    dc_req_ready;
    logic                    dc_req_we;
    logic [ADDR_WIDTH-1:0]   dc_req_addr;
    logic [DATA_WIDTH-1:0]   dc_req_wdata;
    logic [MASK_WIDTH-1:0]   dc_req_wmask;

    logic                    dc_resp_valid;
    logic                    dc_resp_hit;
    logic [DATA_WIDTH-1:0]   dc_resp_data;
    logic                    refill_done;

    logic                    ld_resp_valid;
    logic [TAG_WIDTH-1:0]    ld_resp_tag;
    logic [DATA_WIDTH-1:0]   ld_resp_data;

    modport master (
        input  ld_req_valid, ld_req_addr, ld_req_tag,
        input  st_req_valid, st_req_addr, st_req_data, st_req_wmask, st_buf_count,
        input  flush,
        input  dc_req_ready, dc_resp_valid, dc_resp_hit, dc_resp_data, refill_done,
        output ld_req_ready, st_req_ready,
        output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wmask,
        output ld_resp_valid, ld_resp_tag, ld_resp_data
    );

    modport slave (
        output ld_req_valid, ld_req_addr, ld_req_tag,
        output st_req_valid, st_req_addr, st_req_data, st_req_wmask, st_buf_count,
        output flush,
        output dc_req_ready, dc_resp_valid, dc_resp_hit, dc_resp_data, refill_done,
        input  ld_req_ready, st_req_ready,
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wmask,
        input  ld_resp_valid, ld_resp_tag, ld_resp_data
    );

endinterface

// File: rtl/dcache_port_arbiter_starve_counter.sv
// Saturating count of load grants taken while a store is waiting at the buffer head.
module ld_st_starve_counter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_aL,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat = (cnt_q == W'(LIMIT));

    // Clear wins over increment; hold at the limit once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache port between LSQ loads and the store-buffer drain.
// One request is held in flight; a miss parks it until refill, then it is replayed verbatim.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_aL,
    dcache_port_arbiter_if.master bus
);

    dc_arb_state_t         state_q, state_d;
    dc_hold_t              hold_q, hold_d;
    logic                  ld_resp_valid_q, ld_resp_valid_d;
    logic [TAG_WIDTH-1:0]  ld_resp_tag_q, ld_resp_tag_d;
    logic [DATA_WIDTH-1:0] ld_resp_data_q, ld_resp_data_d;

    dc_hold_t req;
    logic     req_valid;
    logic     ld_elig;
    logic     st_pressure;
    logic     starve_sat;
    logic     st_win;
    logic     ld_win;
    logic     st_grant;
    logic     ld_grant;
    logic     kill_now;

    assign ld_elig     = bus.ld_req_valid & ~bus.flush;
    assign st_pressure = (bus.st_buf_count >= ST_CNT_WIDTH'(ST_HI_WATERMARK));

    ld_st_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .rst_aL (rst_aL),
        .clr    (~bus.st_req_valid | st_grant),
        .inc    (ld_grant & bus.st_req_valid),
        .sat    (starve_sat)
    );

    // Arbitration, issue, response handling and miss/replay sequencing.
    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        ld_resp_valid_d = 1'b0;
        ld_resp_tag_d   = ld_resp_tag_q;
        ld_resp_data_d  = ld_resp_data_q;
        req             = '0;
        req_valid       = 1'b0;
        st_win          = 1'b0;
        ld_win          = 1'b0;
        st_grant        = 1'b0;
        ld_grant        = 1'b0;
        bus.ld_req_ready = 1'b0;
        bus.st_req_ready = 1'b0;
        // A flush arriving in the same cycle as the decision counts as already killed.
        kill_now        = hold_q.killed | (bus.flush & ~hold_q.we);

        unique case (state_q)
            ST_IDLE: begin
                st_win    = bus.st_req_valid & (st_pressure | starve_sat | ~ld_elig);
                ld_win    = ld_elig & ~st_win;
                req_valid = st_win | ld_win;
                req.we    = st_win;
                if (st_win) begin
                    req.addr  = bus.st_req_addr;
                    req.wdata = bus.st_req_data;
                    req.wmask = bus.st_req_wmask;
                end else if (ld_win) begin
                    req.addr = bus.ld_req_addr;
                    req.tag  = bus.ld_req_tag;
                end
                bus.ld_req_ready = ld_win & bus.dc_req_ready;
                if (req_valid && bus.dc_req_ready) begin
                    st_grant = st_win;
                    ld_grant = ld_win;
                    hold_d   = req;
                    state_d  = ST_WAIT_RESP;
                end
            end

            ST_WAIT_RESP: begin
                hold_d.killed = kill_now;
                if (bus.dc_resp_valid) begin
                    if (bus.dc_resp_hit) begin
                        if (hold_q.we) begin
                            bus.st_req_ready = 1'b1;
                        end else if (!kill_now) begin
                            ld_resp_valid_d = 1'b1;
                            ld_resp_tag_d   = hold_q.tag;
                            ld_resp_data_d  = bus.dc_resp_data;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_MISS;
                    end
                end
            end

            ST_MISS: begin
                hold_d.killed = kill_now;
                if (bus.refill_done) begin
                    state_d = kill_now ? ST_IDLE : ST_REPLAY;
                end
            end

            ST_REPLAY: begin
                hold_d.killed = kill_now;
                req           = hold_q;
                req_valid     = 1'b1;
                if (bus.dc_req_ready) begin
                    state_d = ST_WAIT_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.dc_req_valid  = req_valid;
    assign bus.dc_req_we     = req.we;
    assign bus.dc_req_addr   = req.addr;
    assign bus.dc_req_wdata  = req.wdata;
    assign bus.dc_req_wmask  = req.wmask;
    assign bus.ld_resp_valid = ld_resp_valid_q;
    assign bus.ld_resp_tag   = ld_resp_tag_q;
    assign bus.ld_resp_data  = ld_resp_data_q;

    // State, held request and load writeback registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q         <= ST_IDLE;
            hold_q          <= '0;
            ld_resp_valid_q <= 1'b0;
            ld_resp_tag_q   <= '0;
            ld_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            ld_resp_valid_q <= ld_resp_valid_d;
            ld_resp_tag_q   <= ld_resp_tag_d;
            ld_resp_data_q  <= ld_resp_data_d;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios then randomized traffic, all checked
// cycle by cycle against a transaction-level model of the port.
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    localparam int PH_FREE   = 0;  // port available for a new grant
    localparam int PH_RESP   = 1;  // cache answers this cycle
    localparam int PH_MISS   = 2;  // waiting for refill
    localparam int PH_REPLAY = 3;  // held request re-presented

    typedef struct {
        bit                    we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
        logic [TAG_WIDTH-1:0]  tag;
        bit                    killed;
    } txn_t;

    logic clk = 1'b0;
    logic rst_aL;
    always #5 clk = ~clk;

    dcache_port_arbiter_if bus();

    dcache_port_arbiter dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    // model state
    int                    m_phase = PH_FREE;
    int                    m_starve = 0;
    int                    refill_wait = 0;
    txn_t                  m_hold;
    bit                    m_resp_pend = 0;
    logic [TAG_WIDTH-1:0]  m_resp_tag;
    logic [DATA_WIDTH-1:0] m_resp_data;
    int                    n_ld_resp = 0;
    int                    ld_grants = 0;
    int                    st_grants = 0;
    bit                    grant_log[$];

    // stimulus knobs and per-step results
    int                    hit_pct = 100;
    int                    refill_fixed = -1;
    bit                    spur_en = 0;
    bit                    fix_data = 0;
    logic [DATA_WIDTH-1:0] fixed_data = '0;
    bit                    ld_taken = 0;
    bit                    st_done = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(string tag);
        check_eq({tag, "_dc_req_valid"}, bus.dc_req_valid, 0);
        check_eq({tag, "_dc_req_we"}, bus.dc_req_we, 0);
        check_eq({tag, "_dc_req_addr"}, bus.dc_req_addr, 0);
        check_eq({tag, "_ld_req_ready"}, bus.ld_req_ready, 0);
        check_eq({tag, "_st_req_ready"}, bus.st_req_ready, 0);
        check_eq({tag, "_ld_resp_valid"}, bus.ld_resp_valid, 0);
    endtask

    task automatic idle_inputs();
        bus.ld_req_valid  = 0;
        bus.ld_req_addr   = '0;
        bus.ld_req_tag    = '0;
        bus.st_req_valid  = 0;
        bus.st_req_addr   = '0;
        bus.st_req_data   = '0;
        bus.st_req_wmask  = '0;
        bus.st_buf_count  = '0;
        bus.flush         = 0;
        bus.dc_req_ready  = 1;
        bus.dc_resp_valid = 0;
        bus.dc_resp_hit   = 0;
        bus.dc_resp_data  = '0;
        bus.refill_done   = 0;
    endtask

    // One clock: called at a negedge, returns at the next negedge.
    task automatic step();
        bit   ld_elig, st_win, ld_win, req_valid, kill_now, next_pend, resp_hit;
        txn_t cand;
        bus.dc_resp_valid = 0;
        bus.dc_resp_hit   = 0;
        bus.refill_done   = 0;
        bus.dc_resp_data  = fix_data ? fixed_data : $urandom;
        if (m_phase == PH_RESP) begin
            bus.dc_resp_valid = 1;
            bus.dc_resp_hit   = ($urandom_range(0, 99) < hit_pct);
        end else if (spur_en && $urandom_range(0, 15) == 0) begin
            bus.dc_resp_valid = 1;
            bus.dc_resp_hit   = $urandom_range(0, 1);
        end
        if (m_phase == PH_MISS && refill_wait == 0) bus.refill_done = 1;

        ld_elig = bus.ld_req_valid && !bus.flush;
        st_win  = 0;
        ld_win  = 0;
        if (m_phase == PH_FREE) begin
            st_win = bus.st_req_valid &&
                     (bus.st_buf_count >= ST_HI_WATERMARK || m_starve == STARVE_LIMIT || !ld_elig);
            ld_win = ld_elig && !st_win;
        end
        cand = '{default: 0};
        if (m_phase == PH_REPLAY) begin
            cand = m_hold;
        end else if (st_win) begin
            cand.we    = 1;
            cand.addr  = bus.st_req_addr;
            cand.wdata = bus.st_req_data;
            cand.wmask = bus.st_req_wmask;
        end else if (ld_win) begin
            cand.addr = bus.ld_req_addr;
            cand.tag  = bus.ld_req_tag;
        end
        req_valid = st_win || ld_win || (m_phase == PH_REPLAY);
        resp_hit  = bus.dc_resp_hit;

        #1;
        if (rst_aL) begin
            check_eq("dc_req_valid", bus.dc_req_valid, req_valid);
            if (req_valid) begin
                check_eq("dc_req_we", bus.dc_req_we, cand.we);
                check_eq("dc_req_addr", bus.dc_req_addr, cand.addr);
                if (cand.we) begin
                    check_eq("dc_req_wdata", bus.dc_req_wdata, cand.wdata);
                    check_eq("dc_req_wmask", bus.dc_req_wmask, cand.wmask);
                end
            end
            check_eq("ld_req_ready", bus.ld_req_ready, ld_win && bus.dc_req_ready);
            check_eq("st_req_ready", bus.st_req_ready, m_phase == PH_RESP && resp_hit && m_hold.we);
            check_eq("ld_resp_valid", bus.ld_resp_valid, m_resp_pend);
            if (m_resp_pend) begin
                check_eq("ld_resp_tag", bus.ld_resp_tag, m_resp_tag);
                check_eq("ld_resp_data", bus.ld_resp_data, m_resp_data);
            end
        end

        @(posedge clk);
        ld_taken = 0;
        st_done  = 0;
        if (!rst_aL) begin
            m_phase     = PH_FREE;
            m_starve    = 0;
            m_resp_pend = 0;
        end else begin
            kill_now  = m_hold.killed || (bus.flush && !m_hold.we);
            next_pend = 0;
            case (m_phase)
                PH_FREE: begin
                    if (req_valid && bus.dc_req_ready) begin
                        m_hold  = cand;
                        m_phase = PH_RESP;
                        ld_taken = ld_win;
                        grant_log.push_back(st_win);
                        if (st_win) st_grants++;
                        else ld_grants++;
                    end
                end
                PH_RESP: begin
                    m_hold.killed = kill_now;
                    if (resp_hit) begin
                        if (m_hold.we) begin
                            st_done = 1;
                        end else if (!kill_now) begin
                            next_pend   = 1;
                            m_resp_tag  = m_hold.tag;
                            m_resp_data = bus.dc_resp_data;
                            n_ld_resp++;
                        end
                        m_phase = PH_FREE;
                    end else begin
                        m_phase     = PH_MISS;
                        refill_wait = (refill_fixed >= 0) ? refill_fixed : int'($urandom_range(0, 11));
                    end
                end
                PH_MISS: begin
                    m_hold.killed = kill_now;
                    if (refill_wait == 0) m_phase = kill_now ? PH_FREE : PH_REPLAY;
                    else refill_wait--;
                end
                default: begin
                    m_hold.killed = kill_now;
                    if (bus.dc_req_ready) m_phase = PH_RESP;
                end
            endcase
            if (!bus.st_req_valid || (st_win && bus.dc_req_ready)) m_starve = 0;
            else if (ld_win && bus.dc_req_ready && m_starve < STARVE_LIMIT) m_starve++;
            m_resp_pend = next_pend;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.flush        = 0;
        bus.dc_req_ready = 1;
        hit_pct          = 100;
        for (int i = 0; i < 60; i++) begin
            if (ld_taken) bus.ld_req_valid = 0;
            if (st_done) begin
                bus.st_req_valid = 0;
                bus.st_buf_count = '0;
            end
            if (m_phase == PH_FREE && !bus.ld_req_valid && !bus.st_req_valid) break;
            step();
        end
        check_eq("drain_idle", m_phase, PH_FREE);
    endtask

    task automatic drive_random();
        if (ld_taken) begin
            bus.ld_req_addr = $urandom;
            bus.ld_req_tag  = $urandom;
        end
        bus.ld_req_valid = ($urandom_range(0, 3) != 0);
        if (st_done || !bus.st_req_valid) begin
            bus.st_req_valid = ($urandom_range(0, 2) != 0);
            if (bus.st_req_valid) begin
                bus.st_req_addr  = $urandom;
                bus.st_req_data  = $urandom;
                bus.st_req_wmask = $urandom;
            end
        end
        bus.st_buf_count = bus.st_req_valid ? ST_CNT_WIDTH'($urandom_range(1, ST_BUF_N_ENTRIES)) : '0;
        bus.flush        = ($urandom_range(0, 11) == 0);
        bus.dc_req_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int s0, l0, r0;
        m_hold = '{default: 0};
        rst_aL = 0;
        idle_inputs();
        @(negedge clk);
        step();
        step();
        rst_aL = 1;
        #1;
        check_quiet("reset");
        @(negedge clk);

        // load hit: 0x100 tag 3 returns 0xDEADBEEF two cycles after accept
        fix_data   = 1;
        fixed_data = 32'hDEADBEEF;
        bus.ld_req_valid = 1;
        bus.ld_req_addr  = 32'h100;
        bus.ld_req_tag   = 5'd3;
        step();
        bus.ld_req_valid = 0;
        step();
        check_eq("hit_resp_valid", bus.ld_resp_valid, 1);
        check_eq("hit_resp_tag", bus.ld_resp_tag, 3);
        check_eq("hit_resp_data", bus.ld_resp_data, 32'hDEADBEEF);
        fix_data = 0;
        drain();

        // store at watermark beats a pending load
        bus.st_req_valid = 1;
        bus.st_req_addr  = 32'h200;
        bus.st_req_data  = 32'h1234_5678;
        bus.st_req_wmask = 4'hF;
        bus.st_buf_count = 4'd6;
        bus.ld_req_valid = 1;
        bus.ld_req_addr  = 32'h300;
        bus.ld_req_tag   = 5'd7;
        s0 = st_grants;
        l0 = ld_grants;
        step();
        check_eq("prio_store_first", st_grants - s0, 1);
        check_eq("prio_no_load", ld_grants - l0, 0);
        step();
        check_eq("prio_store_done", st_done, 1);
        drain();

        // starvation: four loads then the waiting store
        idle_inputs();
        step();
        grant_log.delete();
        bus.st_req_valid = 1;
        bus.st_req_addr  = 32'h240;
        bus.st_req_data  = 32'hA5A5_0F0F;
        bus.st_req_wmask = 4'h3;
        bus.st_buf_count = 4'd2;
        bus.ld_req_valid = 1;
        bus.ld_req_addr  = 32'h400;
        bus.ld_req_tag   = 5'd0;
        for (int i = 0; i < 40 && grant_log.size() < 5; i++) begin
            step();
            if (ld_taken) begin
                bus.ld_req_tag  = bus.ld_req_tag + 5'd1;
                bus.ld_req_addr = bus.ld_req_addr + 32'd4;
            end
            if (st_done) begin
                bus.st_req_valid = 0;
                bus.st_buf_count = '0;
            end
        end
        check_eq("starve_grants", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check_eq($sformatf("starve_order%0d", i), grant_log[i], (i == 4));
        end
        drain();

        // miss, refill ten cycles later, replay hits
        idle_inputs();
        bus.ld_req_valid = 1;
        bus.ld_req_addr  = 32'h500;
        bus.ld_req_tag   = 5'd9;
        r0 = n_ld_resp;
        step();
        bus.ld_req_valid = 0;
        hit_pct      = 0;
        refill_fixed = 9;
        step();
        hit_pct = 100;
        drain();
        step();
        check_eq("miss_replay_resp", n_ld_resp - r0, 1);

        // flush during miss: back to idle after refill, no writeback
        bus.ld_req_valid = 1;
        bus.ld_req_addr  = 32'h600;
        bus.ld_req_tag   = 5'd11;
        r0 = n_ld_resp;
        step();
        bus.ld_req_valid = 0;
        hit_pct = 0;
        step();
        hit_pct = 100;
        step();
        bus.flush = 1;
        step();
        bus.flush = 0;
        drain();
        step();
        check_eq("flush_no_resp", n_ld_resp - r0, 0);

        // reset in the middle of a miss
        bus.ld_req_valid = 1;
        bus.ld_req_addr  = 32'h700;
        bus.ld_req_tag   = 5'd13;
        step();
        bus.ld_req_valid = 0;
        hit_pct      = 0;
        refill_fixed = 20;
        step();
        hit_pct = 100;
        step();
        step();
        rst_aL = 0;
        idle_inputs();
        step();
        rst_aL = 1;
        #1;
        check_quiet("rst_mid_miss");
        @(negedge clk);
        for (int i = 0; i < 25; i++) step();
        refill_fixed = -1;

        // randomized traffic
        spur_en = 1;
        hit_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            step();
        end
        spur_en = 0;
        bus.ld_req_valid = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
